pll_cfg_sequencer: RTL and testbench

- Bus initiator that drives the PLL controller's register port (address / rd0_wr1 / wr_data / valid in; rd_data / rd_valid / ready back).
- Runs the full bring-up sequence autonomously on a single start pulse: hold PLL in reset, program mul/div, enable, poll lock status, then switch the SoC clock.
- Sits in the i_clk_ahb domain in front of the PLL controller and replaces firmware-driven bring-up.

---
 rtl/pll_cfg_sequencer.sv | 251 +++++++++++++++++++++++++
 tb/tb_pll_cfg_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_cfg_sequencer.sv
// pll_cfg_sequencer: autonomous PLL bring-up initiator on the PLL controller's
// register port. A single start pulse runs the sequence: hold the PLL in reset
// with bypass, program mul/div, enable, poll lock status, then switch the SoC
// clock onto the PLL. Failures park the PLL in bypass and report an error code.
//
// Optional build macro PLL_SEQ_RETRY_EN: the first lock timeout restarts the
// sequence once from the reset write with the same mul/div.
module pll_cfg_sequencer #(
    parameter logic [31:0] CTRL_ADDR   = 32'h0000_0000,
    parameter logic [31:0] CFG_ADDR    = 32'h0000_0004,
    parameter logic [31:0] STAT_ADDR   = 32'h0000_0008,
    parameter int unsigned POLL_GAP    = 16,
    parameter int unsigned MAX_POLLS   = 64,
    parameter int unsigned RSP_TIMEOUT = 32
) (
    input  logic        i_clk_ahb,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [7:0]  i_mul,
    input  logic [7:0]  i_div,
    output logic [31:0] o_address,
    output logic        o_rd0_wr1,
    output logic [31:0] o_wr_data,
    output logic        o_valid,
    input  logic        i_ready,
    input  logic [31:0] i_rd_data,
    input  logic        i_rd_valid,
    output logic        o_busy,
    output logic        o_done,
    output logic [1:0]  o_err_code,
    output logic        o_locked
);

    localparam int PCW = $clog2(MAX_POLLS + 1);
    localparam int GCW = $clog2(POLL_GAP + 1);
    localparam int RCW = $clog2(RSP_TIMEOUT + 1);

    localparam logic [PCW-1:0] POLL_LAST = PCW'(MAX_POLLS - 1);
    localparam logic [GCW-1:0] GAP_LAST  = GCW'(POLL_GAP - 1);
    localparam logic [RCW-1:0] RSP_LAST  = RCW'(RSP_TIMEOUT - 1);

    localparam logic [31:0] CTRL_RST_BYP = 32'h0000_0006;
    localparam logic [31:0] CTRL_EN      = 32'h0000_0001;
    localparam logic [31:0] CTRL_EN_SEL  = 32'h0000_0009;
    localparam logic [31:0] CTRL_BYP     = 32'h0000_0002;

    localparam logic [1:0] ERR_OK  = 2'd0;
    localparam logic [1:0] ERR_CFG = 2'd1;
    localparam logic [1:0] ERR_PLL = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_RST,
        ST_WR_CFG,
        ST_WR_EN,
        ST_RD_STAT,
        ST_WAIT_RD,
        ST_GAP,
        ST_WR_SEL,
        ST_SAFE,
        ST_DONE
    } state_t;

    state_t         state_q, state_d;
    logic           bus_acc;
    logic           acc_q;
    logic           req;
    logic           start_ok;
    logic           err_load;
    logic [1:0]     err_val;
    logic           lock_set;
    logic           tmo;
    logic           can_retry;
    logic [7:0]     mul_q, div_q;
    logic [1:0]     err_q;
    logic           locked_q;
    logic [PCW-1:0] poll_cnt_q;
    logic [GCW-1:0] gap_cnt_q;
    logic [RCW-1:0] rsp_cnt_q;
    logic           unused_rd_bits;

    // Only the locked/error bits of the status word steer the sequence.
    assign unused_rd_bits = &{1'b0, i_rd_data[31:2]};

    assign bus_acc = o_valid && i_ready;

    // State register.
    always_ff @(posedge i_clk_ahb) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus the one-cycle strobes that update the datapath.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned and no latch is inferred.
        state_d  = state_q;
        start_ok = 1'b0;
        err_load = 1'b0;
        err_val  = ERR_OK;
        lock_set = 1'b0;
        tmo      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    err_load = 1'b1;
                    if (i_mul == 8'd0 || i_div == 8'd0) begin
                        err_val = ERR_CFG;
                        state_d = ST_DONE;
                    end else begin
                        err_val  = ERR_OK;
                        start_ok = 1'b1;
                        state_d  = ST_WR_RST;
                    end
                end
            end
            ST_WR_RST:  if (bus_acc) state_d = ST_WR_CFG;
            ST_WR_CFG:  if (bus_acc) state_d = ST_WR_EN;
            ST_WR_EN:   if (bus_acc) state_d = ST_RD_STAT;
            ST_RD_STAT: if (bus_acc) state_d = ST_WAIT_RD;
            ST_WAIT_RD: begin
                if (i_rd_valid) begin
                    if (i_rd_data[1]) begin
                        state_d  = ST_SAFE;
                        err_load = 1'b1;
                        err_val  = ERR_PLL;
                    end else if (i_rd_data[0]) begin
                        state_d = ST_WR_SEL;
                    end else if (poll_cnt_q == POLL_LAST) begin
                        tmo = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                    end
                end else if (rsp_cnt_q == RSP_LAST) begin
                    tmo = 1'b1;
                end
                if (tmo) begin
                    if (can_retry) begin
                        state_d = ST_WR_RST;
                    end else begin
                        state_d  = ST_SAFE;
                        err_load = 1'b1;
                        err_val  = ERR_TMO;
                    end
                end
            end
            ST_GAP:     if (gap_cnt_q == GAP_LAST) state_d = ST_RD_STAT;
            ST_WR_SEL: begin
                if (bus_acc) begin
                    lock_set = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_SAFE:    if (bus_acc) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Bus request and status outputs decoded from the current state.
    always_comb begin
        req       = 1'b0;
        o_address = 32'h0;
        o_rd0_wr1 = 1'b0;
        o_wr_data = 32'h0;
        case (state_q)
            ST_WR_RST: begin
                req = 1'b1; o_address = CTRL_ADDR; o_rd0_wr1 = 1'b1; o_wr_data = CTRL_RST_BYP;
            end
            ST_WR_CFG: begin
                req = 1'b1; o_address = CFG_ADDR; o_rd0_wr1 = 1'b1; o_wr_data = {16'h0, div_q, mul_q};
            end
            ST_WR_EN: begin
                req = 1'b1; o_address = CTRL_ADDR; o_rd0_wr1 = 1'b1; o_wr_data = CTRL_EN;
            end
            ST_RD_STAT: begin
                req = 1'b1; o_address = STAT_ADDR;
            end
            ST_WR_SEL: begin
                req = 1'b1; o_address = CTRL_ADDR; o_rd0_wr1 = 1'b1; o_wr_data = CTRL_EN_SEL;
            end
            ST_SAFE: begin
                req = 1'b1; o_address = CTRL_ADDR; o_rd0_wr1 = 1'b1; o_wr_data = CTRL_BYP;
            end
            default: req = 1'b0;
        endcase
        // The cycle after any acceptance is always idle on the bus, even when
        // the next state issues another request straight away.
        o_valid    = req && !acc_q;
        o_busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
        o_done     = (state_q == ST_DONE);
        o_err_code = err_q;
        o_locked   = locked_q;
    end

    // Latched configuration, result registers and the poll/gap/response counters.
    always_ff @(posedge i_clk_ahb) begin
        if (i_rst) begin
            acc_q      <= 1'b0;
            mul_q      <= 8'd0;
            div_q      <= 8'd0;
            err_q      <= ERR_OK;
            locked_q   <= 1'b0;
            poll_cnt_q <= '0;
            gap_cnt_q  <= '0;
            rsp_cnt_q  <= '0;
        end else begin
            acc_q <= bus_acc;
            if (start_ok) begin
                mul_q    <= i_mul;
                div_q    <= i_div;
                locked_q <= 1'b0;
            end
            if (lock_set) locked_q <= 1'b1;
            if (err_load) err_q <= err_val;
            if (state_q == ST_WR_EN) begin
                poll_cnt_q <= '0;
            end else if (state_q == ST_WAIT_RD && i_rd_valid && i_rd_data[1:0] == 2'b00) begin
                poll_cnt_q <= poll_cnt_q + PCW'(1);
            end
            rsp_cnt_q <= (state_q == ST_WAIT_RD) ? rsp_cnt_q + RCW'(1) : '0;
            gap_cnt_q <= (state_q == ST_GAP) ? gap_cnt_q + GCW'(1) : '0;
        end
    end

`ifdef PLL_SEQ_RETRY_EN
    logic retry_used_q;

    // One retry per start: armed on start, spent on the first lock timeout.
    always_ff @(posedge i_clk_ahb) begin
        if (i_rst) begin
            retry_used_q <= 1'b0;
        end else if (start_ok) begin
            retry_used_q <= 1'b0;
        end else if (tmo) begin
            retry_used_q <= 1'b1;
        end
    end

    assign can_retry = !retry_used_q;
`else
    assign can_retry = 1'b0;
`endif

endmodule

// File: tb/tb_pll_cfg_sequencer.sv
// Testbench for pll_cfg_sequencer: directed and randomized bring-up runs with
// a bus target model and a transaction-level reference model.
module tb_pll_cfg_sequencer;

    localparam int PG = 3;
    localparam int MP = 4;
    localparam int RT = 8;
    localparam logic [31:0] CTRL = 32'h0;
    localparam logic [31:0] CFG  = 32'h4;
    localparam logic [31:0] STAT = 32'h8;
`ifdef PLL_SEQ_RETRY_EN
    localparam int ATTEMPTS = 2;
`else
    localparam int ATTEMPTS = 1;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic        rw;
        logic [31:0] data;
    } txn_t;

    typedef struct {
        bit          drop;
        logic [31:0] data;
        int          lat;
    } rsp_t;

    logic        clk = 1'b0;
    logic        i_rst, i_start;
    logic [7:0]  i_mul, i_div;
    logic [31:0] o_address, o_wr_data, i_rd_data;
    logic        o_rd0_wr1, o_valid, i_ready, i_rd_valid;
    logic        o_busy, o_done, o_locked;
    logic [1:0]  o_err_code;

    int   n_pass = 0;
    int   n_fail = 0;
    int   n_total = 0;

    rsp_t script[$];
    rsp_t rsp_q[$];
    txn_t exp_q[$];
    txn_t act_q[$];
    int   gap_q[$];
    int   exp_gaps;
    logic [1:0] exp_err;
    logic exp_locked;
    logic last_locked = 1'b0;

    int   stab_err, drop_err, stall_left, stall_seen;
    bit   rdy_rand = 1'b0;
    bit   spur_en = 1'b0;

    always #5 clk = ~clk;

    pll_cfg_sequencer #(
        .POLL_GAP(PG), .MAX_POLLS(MP), .RSP_TIMEOUT(RT)
    ) dut (
        .i_clk_ahb(clk), .i_rst(i_rst), .i_start(i_start),
        .i_mul(i_mul), .i_div(i_div),
        .o_address(o_address), .o_rd0_wr1(o_rd0_wr1), .o_wr_data(o_wr_data),
        .o_valid(o_valid), .i_ready(i_ready),
        .i_rd_data(i_rd_data), .i_rd_valid(i_rd_valid),
        .o_busy(o_busy), .o_done(o_done), .o_err_code(o_err_code), .o_locked(o_locked)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic add_rsp(input bit drop, input logic [31:0] data, input int lat);
        rsp_t r;
        r.drop = drop; r.data = data; r.lat = lat;
        script.push_back(r);
    endtask

    // Reference: the ordered list of bus transfers and the final result of one
    // start, derived from the bring-up rules and the scripted status replies.
    function automatic void build_model(input logic [7:0] mul, input logic [7:0] div);
        int si = 0;
        exp_q.delete();
        exp_gaps = 0;
        if (mul == 8'd0 || div == 8'd0) begin
            exp_err = 2'd1;
            exp_locked = last_locked;
            return;
        end
        exp_locked = 1'b0;
        for (int att = 0; att < ATTEMPTS; att++) begin
            exp_q.push_back('{CTRL, 1'b1, 32'h6});
            exp_q.push_back('{CFG, 1'b1, {16'h0, div, mul}});
            exp_q.push_back('{CTRL, 1'b1, 32'h1});
            for (int p = 1; p <= MP; p++) begin
                rsp_t r;
                exp_q.push_back('{STAT, 1'b0, 32'h0});
                if (si < script.size()) r = script[si];
                else begin r.drop = 1'b1; r.data = 32'h0; r.lat = 0; end
                si++;
                if (r.drop) break;
                if (r.data[1]) begin
                    exp_q.push_back('{CTRL, 1'b1, 32'h2});
                    exp_err = 2'd2;
                    return;
                end
                if (r.data[0]) begin
                    exp_q.push_back('{CTRL, 1'b1, 32'h9});
                    exp_err = 2'd0;
                    exp_locked = 1'b1;
                    return;
                end
                if (p < MP) exp_gaps++;
            end
        end
        exp_q.push_back('{CTRL, 1'b1, 32'h2});
        exp_err = 2'd3;
    endfunction

    // Bus target: ready generation, read responses, protocol observation.
    initial begin : bus_target
        bit ready, prev_pend, prev_acc, gap_run, rsp_drop;
        logic [31:0] p_addr, p_data, rsp_data;
        logic p_rw;
        int rsp_left, gap_cnt;
        rsp_t r;
        i_ready = 1'b0; i_rd_valid = 1'b0; i_rd_data = 32'h0;
        prev_pend = 0; prev_acc = 0; gap_run = 0; rsp_drop = 0;
        rsp_left = 0; gap_cnt = 0; p_addr = 0; p_data = 0; p_rw = 0; rsp_data = 0;
        forever begin
            @(negedge clk);
            if (i_rst) begin
                prev_pend = 0; prev_acc = 0; gap_run = 0; rsp_left = 0;
                i_ready = 1'b0; i_rd_valid = 1'b0;
            end else begin
                if (prev_pend && !(o_valid && o_address == p_addr &&
                                   o_rd0_wr1 == p_rw && o_wr_data == p_data))
                    stab_err++;
                if (prev_acc && o_valid) drop_err++;
                if (gap_run) begin
                    if (o_valid) begin
                        if (!o_rd0_wr1) gap_q.push_back(gap_cnt);
                        gap_run = 0;
                    end else begin
                        gap_cnt++;
                    end
                end
                i_rd_valid = 1'b0;
                i_rd_data = $urandom;
                if (rsp_left > 0) begin
                    rsp_left--;
                    if (rsp_left == 0 && !rsp_drop) begin
                        i_rd_valid = 1'b1;
                        i_rd_data = rsp_data;
                        gap_run = 1;
                        gap_cnt = 0;
                    end
                end else if (spur_en && $urandom_range(0, 2) == 0) begin
                    i_rd_valid = 1'b1;
                    i_rd_data = 32'h3;
                end
                ready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (o_valid && o_rd0_wr1 && o_address == CFG && stall_left > 0) begin
                    ready = 1'b0;
                    stall_left--;
                    stall_seen++;
                end
                i_ready = ready;
                if (o_valid && ready) begin
                    act_q.push_back('{o_address, o_rd0_wr1, o_wr_data});
                    if (!o_rd0_wr1) begin
                        if (rsp_q.size() > 0) r = rsp_q.pop_front();
                        else begin r.drop = 1'b1; r.data = 32'h0; r.lat = 0; end
                        rsp_drop = r.drop;
                        rsp_data = r.data;
                        rsp_left = r.drop ? RT + 2 : r.lat;
                    end
                end
                prev_pend = o_valid && !ready;
                prev_acc = o_valid && ready;
                p_addr = o_address; p_rw = o_rd0_wr1; p_data = o_wr_data;
            end
        end
    end

    // One start-to-done run, compared against the reference model.
    task automatic run(input string nm, input logic [7:0] mul, input logic [7:0] div,
                       input bit rnd, input bit spur, input bit poke, input int stall);
        int  cyc;
        bit  bad;
        bad = (mul == 8'd0) || (div == 8'd0);
        act_q.delete(); gap_q.delete();
        stab_err = 0; drop_err = 0; stall_seen = 0; stall_left = stall;
        rsp_q = script; rdy_rand = rnd; spur_en = spur;
        build_model(mul, div);
        i_start = 1'b1; i_mul = mul; i_div = div;
        @(negedge clk);
        i_start = 1'b0; i_mul = 8'($urandom); i_div = 8'($urandom);
        if (bad) check($sformatf("%s_done_next", nm), 32'(o_done), 32'd1);
        else     check($sformatf("%s_busy", nm), 32'(o_busy), 32'd1);
        cyc = 0;
        while (o_done !== 1'b1 && cyc < 3000) begin
            i_start = poke && (cyc == 2);
            if (i_start) i_mul = 8'd0;
            @(negedge clk);
            cyc++;
        end
        i_start = 1'b0;
        check($sformatf("%s_done", nm), 32'(o_done), 32'd1);
        check($sformatf("%s_err", nm), 32'(o_err_code), 32'(exp_err));
        check($sformatf("%s_locked", nm), 32'(o_locked), 32'(exp_locked));
        check($sformatf("%s_busy_end", nm), 32'(o_busy), 32'd0);
        @(negedge clk);
        check($sformatf("%s_done_width", nm), 32'(o_done), 32'd0);
        check($sformatf("%s_err_held", nm), 32'(o_err_code), 32'(exp_err));
        check($sformatf("%s_ntxn", nm), act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            check($sformatf("%s_t%0d_addr", nm, i), act_q[i].addr, exp_q[i].addr);
            check($sformatf("%s_t%0d_rw", nm, i), 32'(act_q[i].rw), 32'(exp_q[i].rw));
            check($sformatf("%s_t%0d_data", nm, i), act_q[i].data, exp_q[i].data);
        end
        check($sformatf("%s_stable", nm), stab_err, 0);
        check($sformatf("%s_valid_drop", nm), drop_err, 0);
        check($sformatf("%s_ngaps", nm), gap_q.size(), exp_gaps);
        foreach (gap_q[i]) check($sformatf("%s_gap%0d", nm, i), gap_q[i], PG);
        if (stall > 0) check($sformatf("%s_stall", nm), stall_seen, stall);
        last_locked = exp_locked;
        spur_en = 1'b0;
        rdy_rand = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cyc;
        int n;
        int kind;
        i_rst = 1'b1; i_start = 1'b0; i_mul = 8'd0; i_div = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_addr", o_address, 32'h0);
        check("rst_wdata", o_wr_data, 32'h0);
        check("rst_ctl", 32'({o_valid, o_rd0_wr1, o_busy, o_done, o_err_code, o_locked}), 32'h0);
        i_rst = 1'b0;
        @(negedge clk);
        check("idle_ctl", 32'({o_valid, o_busy, o_done, o_err_code, o_locked}), 32'h0);

        script.delete(); add_rsp(0, 32'h1, 2);
        run("nominal", 8'd20, 8'd2, 0, 0, 0, 0);

        script.delete(); add_rsp(0, 32'h1, 3);
        run("cfg_stall", 8'd20, 8'd2, 0, 0, 0, 5);

        script.delete();
        run("bad_div", 8'd5, 8'd0, 0, 0, 0, 0);

        script.delete();
        for (int i = 0; i < 2 * MP; i++) add_rsp(0, 32'h0, 1 + i % 3);
        run("poll_tmo", 8'd7, 8'd3, 0, 0, 0, 0);

        script.delete(); add_rsp(0, 32'h3, 2);
        run("pll_err", 8'd9, 8'd9, 0, 0, 0, 0);

        script.delete();
        run("bad_mul", 8'd0, 8'd4, 0, 0, 0, 0);

        script.delete(); add_rsp(1, 32'h0, 0); add_rsp(1, 32'h0, 0);
        run("rsp_tmo", 8'd15, 8'd1, 0, 0, 0, 0);

        script.delete(); add_rsp(0, 32'h0, 1); add_rsp(0, 32'hFFFF_FFFD, 4);
        run("busy_start", 8'd11, 8'd4, 0, 0, 1, 0);

        // Reset while the enable write is being offered.
        script.delete(); add_rsp(0, 32'h1, 1);
        rsp_q = script; rdy_rand = 1'b1; spur_en = 1'b0; stall_left = 0;
        i_start = 1'b1; i_mul = 8'd33; i_div = 8'd5;
        @(negedge clk);
        i_start = 1'b0;
        cyc = 0;
        while (!(o_valid && o_rd0_wr1 && o_address == CTRL && o_wr_data == 32'h1) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_wr_en_seen", 32'(cyc < 200), 32'd1);
        i_rst = 1'b1;
        @(negedge clk);
        check("midrst_addr", o_address, 32'h0);
        check("midrst_wdata", o_wr_data, 32'h0);
        check("midrst_ctl", 32'({o_valid, o_rd0_wr1, o_busy, o_done, o_err_code, o_locked}), 32'h0);
        act_q.delete();
        rdy_rand = 1'b0;
        @(negedge clk);
        i_rst = 1'b0;
        repeat (6) @(negedge clk);
        check("midrst_no_traffic", act_q.size(), 0);
        check("midrst_idle_valid", 32'(o_valid), 32'd0);
        last_locked = 1'b0;
        script.delete(); add_rsp(0, 32'h0, 2); add_rsp(0, 32'h1, 1);
        run("post_rst", 8'd20, 8'd2, 0, 0, 0, 0);

        for (int t = 0; t < 8; t++) begin
            script.delete();
            n = $urandom_range(0, MP + 1);
            for (int i = 0; i < n; i++)
                add_rsp(0, $urandom & ~32'h3, $urandom_range(1, RT - 2));
            kind = $urandom_range(0, 2);
            if (kind == 0)      add_rsp(0, ($urandom & ~32'h2) | 32'h1, $urandom_range(1, RT - 2));
            else if (kind == 1) add_rsp(0, $urandom | 32'h2, $urandom_range(1, RT - 2));
            else                add_rsp(1, 32'h0, 0);
            run($sformatf("rand%0d", t), 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)),
                1, 1, 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
